pre_ram_loader: RTL and testbench
=================================

PRE_RAM_LOADER -- requirements
Module: pre_ram_loader

Interface
REQ-001 Parameter: ADDR_W, 8, Pre_ram word-address width.
REQ-002 Parameter: WORD_BYTES, 8, bytes per 64-bit Pre_ram write word.
REQ-003 Parameter: MAX_BYTES, 256, bytes per tile (equal to the 256*8-bit Pre_ram read width).
REQ-004 Port: clk  input  1  single clock; all logic rising-edge.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: start  input  1  one-cycle request to load one tile; sampled only in IDLE.
REQ-007 Port: base_addr  input  ADDR_W  first Pre_ram word address of the tile; latched on accepted start.
REQ-008 Port: num_bytes  input  9  tile length in bytes, 1..256; latched on accepted start.
REQ-009 Port: s_valid  input  1  upstream byte valid.
REQ-010 Port: s_data  input  8  upstream byte.
REQ-011 Port: s_ready  output  1  loader accepts s_data this cycle; a transfer occurs when s_valid and s_ready are both high.
REQ-012 Port: ram_we  output  1  Pre_ram write enable.
REQ-013 Port: ram_addr  output  ADDR_W  Pre_ram address for write or read request.
REQ-014 Port: ram_data  output  64  Pre_ram write data.
REQ-015 Port: ram_read_req  output  1  Pre_ram read request issued after the tile is written.
REQ-016 Port: busy  output  1  high in every state except IDLE.
REQ-017 Port: done  output  1  one-cycle pulse when the tile is fully written and read requested.

Function
REQ-018 FSM states SHALL be IDLE, FILL, WRITE, READ, DONE.
REQ-019 IDLE: start=1 with num_bytes in 1..256 SHALL latch base_addr and num_bytes, clear the byte lane counter, word counter and pack register, and go to FILL; start with num_bytes=0 or num_bytes>256 SHALL be ignored.
REQ-020 start outside IDLE SHALL be ignored.
REQ-021 FILL: s_ready=1; each transfer SHALL write s_data into lane k (bits 8k+7:8k, little-endian, k=0 first) and increment k and the accepted-byte count.
REQ-022 FILL SHALL go to WRITE in the cycle after lane 7 is filled or the last tile byte (count==num_bytes) is accepted.
REQ-023 WRITE: s_ready=0, ram_we=1 for exactly one cycle, ram_addr=(base_addr+word_cnt) mod 2^ADDR_W, ram_data=pack register; unfilled lanes of a final partial word SHALL be zero.
REQ-024 After WRITE: word_cnt increments, pack register and lane counter clear; next state is FILL if bytes remain, else READ.
REQ-025 READ: ram_read_req=1 for exactly one cycle with ram_addr=base_addr, ram_we=0; next state is DONE.
REQ-026 DONE: done=1 for one cycle, then IDLE.
REQ-027 Throughput: one full word per 9 cycles with s_valid held high; s_valid gaps SHALL stall FILL without data loss.
REQ-028 ram_we and ram_read_req SHALL never be high in the same cycle; s_ready SHALL be 0 outside FILL.
REQ-029 Word address wrap-around past 2^ADDR_W-1 to 0 SHALL be silent.
REQ-030 ram_addr and ram_data SHALL hold their last values when ram_we and ram_read_req are both low.

Reset
REQ-031 reset SHALL asynchronously force state=IDLE and s_ready, ram_we, ram_read_req, busy, done=0, with ram_addr, ram_data, counters and latched parameters =0.
REQ-032 Reset mid-tile SHALL abandon the tile with no further write or read request; after reset release the block SHALL accept a new start.

Structure
REQ-033 Package pre_ram_pkg SHALL hold the FSM state enum, ADDR_W, WORD_BYTES and MAX_BYTES defaults.
REQ-034 One sub-module, pre_ram_byte_packer (lane register, lane counter, clear and full flags), SHALL be instantiated; the FSM and address generation live in pre_ram_loader.

Verification
REQ-035 base_addr=10, num_bytes=16, bytes 0x00..0x0F streamed with s_valid held high -> writes addr10=0x0706050403020100, addr11=0x0F0E0D0C0B0A0908, then ram_read_req with addr10, then done.
REQ-036 base_addr=20, num_bytes=3, bytes A5,5A,C3 -> single write addr20 data=0x0000000000C35AA5, read_req addr20, done.
REQ-037 base_addr=254, num_bytes=32 -> writes to addresses 254,255,0,1 in order; read_req addr254.
REQ-038 s_valid toggling every other cycle, num_bytes=8 -> one correct write, no byte duplicated or dropped; start pulsed during FILL has no effect.
REQ-039 reset asserted after 5 of 16 bytes accepted -> ram_we, ram_read_req, done stay 0; new start (base_addr=0, num_bytes=8) completes normally.
REQ-040 start with num_bytes=0 -> busy stays 0, no RAM activity.

Source files
------------

// File: rtl/pre_ram_pkg.sv
// Shared definitions for the Pre_ram tile loader: default sizes and FSM states.
package pre_ram_pkg;

   localparam int DEF_ADDR_W     = 8;    // Pre_ram word-address width
   localparam int DEF_WORD_BYTES = 8;    // bytes per 64-bit Pre_ram write word
   localparam int DEF_MAX_BYTES  = 256;  // bytes per tile (one 2048-bit Pre_ram read)

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      FILL  = 3'd1,
      WRITE = 3'd2,
      READ  = 3'd3,
      DONE  = 3'd4
   } state_t;

endpackage

// File: rtl/pre_ram_byte_packer.sv
// Packs an incoming byte stream little-endian into one Pre_ram write word.
// Lane 0 lands in bits 7:0. Clear zeroes every lane, so a final partial
// word carries zeros in its unfilled lanes.
module pre_ram_byte_packer #(
   parameter int WORD_BYTES = 8,
   parameter int LANE_W     = $clog2(WORD_BYTES)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    clear,
   input  logic                    wr_en,
   input  logic [7:0]              wr_data,
   output logic [WORD_BYTES*8-1:0] word,
   output logic                    full
);

   logic [LANE_W-1:0] lane_reg;

   // Lane counter: advances per accepted byte and wraps after the last lane.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         lane_reg <= '0;
      end else if (clear) begin
         lane_reg <= '0;
      end else if (wr_en) begin
         lane_reg <= lane_reg + 1'b1;
      end
   end

   // One byte register per lane; only the lane currently pointed at is written.
   for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
      logic [7:0] byte_reg;

      // Capture the byte when this lane is the active one.
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            byte_reg <= 8'h00;
         end else if (clear) begin
            byte_reg <= 8'h00;
         end else if (wr_en && (lane_reg == LANE_W'(gi))) begin
            byte_reg <= wr_data;
         end
      end

      assign word[gi*8 +: 8] = byte_reg;
   end

   // The byte being written right now completes the word.
   assign full = wr_en && (lane_reg == LANE_W'(WORD_BYTES - 1));

endmodule

// File: rtl/pre_ram_loader.sv
// Loads one tile of bytes into Pre_ram as 64-bit words starting at base_addr,
// then issues a single wide read request at base_addr and pulses done.
module pre_ram_loader
   import pre_ram_pkg::*;
#(
   parameter int ADDR_W     = DEF_ADDR_W,
   parameter int WORD_BYTES = DEF_WORD_BYTES,
   parameter int MAX_BYTES  = DEF_MAX_BYTES
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [ADDR_W-1:0]       base_addr,
   input  logic [8:0]              num_bytes,
   input  logic                    s_valid,
   input  logic [7:0]              s_data,
   output logic                    s_ready,
   output logic                    ram_we,
   output logic [ADDR_W-1:0]       ram_addr,
   output logic [WORD_BYTES*8-1:0] ram_data,
   output logic                    ram_read_req,
   output logic                    busy,
   output logic                    done
);

   state_t                  state_reg, state_next;
   logic [ADDR_W-1:0]       base_reg;
   logic [8:0]              num_reg;
   logic [8:0]              byte_cnt_reg;
   logic [ADDR_W-1:0]       word_cnt_reg;
   logic [ADDR_W-1:0]       addr_hold_reg;
   logic [WORD_BYTES*8-1:0] data_hold_reg;

   logic                    accept_start;
   logic                    xfer;
   logic                    last_byte;
   logic                    pk_clear;
   logic                    pk_full;
   logic [WORD_BYTES*8-1:0] pk_word;
   logic [ADDR_W-1:0]       word_addr;

   // Only a start in IDLE with a length of 1..MAX_BYTES opens a tile.
   assign accept_start = (state_reg == IDLE) && start &&
                         (num_bytes != 9'd0) && (num_bytes <= 9'(MAX_BYTES));
   assign xfer         = (state_reg == FILL) && s_valid;
   assign last_byte    = xfer && ((byte_cnt_reg + 9'd1) == num_reg);
   assign pk_clear     = accept_start || (state_reg == WRITE);
   assign word_addr    = base_reg + word_cnt_reg;   // wraps silently

   pre_ram_byte_packer #(
      .WORD_BYTES (WORD_BYTES)
   ) u_packer (
      .clk     (clk),
      .reset   (reset),
      .clear   (pk_clear),
      .wr_en   (xfer),
      .wr_data (s_data),
      .word    (pk_word),
      .full    (pk_full)
   );

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg <= IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic: fill a word, write it, repeat until the tile is in, then read.
   always_comb begin
      state_next = state_reg;
      unique case (state_reg)
         IDLE:    if (accept_start) state_next = FILL;
         FILL:    if (pk_full || last_byte) state_next = WRITE;
         WRITE:   state_next = (byte_cnt_reg < num_reg) ? FILL : READ;
         READ:    state_next = DONE;
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Outputs: strobes decode the state; address/data fall back to held values when idle.
   always_comb begin
      s_ready      = (state_reg == FILL);
      ram_we       = (state_reg == WRITE);
      ram_read_req = (state_reg == READ);
      busy         = (state_reg != IDLE);
      done         = (state_reg == DONE);
      ram_addr     = addr_hold_reg;
      ram_data     = data_hold_reg;
      if (state_reg == WRITE) begin
         ram_addr = word_addr;
         ram_data = pk_word;
      end else if (state_reg == READ) begin
         ram_addr = base_reg;
      end
   end

   // Tile parameters, byte/word counters and the last-driven address/data.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_reg      <= '0;
         num_reg       <= '0;
         byte_cnt_reg  <= '0;
         word_cnt_reg  <= '0;
         addr_hold_reg <= '0;
         data_hold_reg <= '0;
      end else begin
         if (accept_start) begin
            base_reg     <= base_addr;
            num_reg      <= num_bytes;
            byte_cnt_reg <= '0;
            word_cnt_reg <= '0;
         end
         if (xfer) begin
            byte_cnt_reg <= byte_cnt_reg + 9'd1;
         end
         if (state_reg == WRITE) begin
            word_cnt_reg  <= word_cnt_reg + 1'b1;
            addr_hold_reg <= word_addr;
            data_hold_reg <= pk_word;
         end
         if (state_reg == READ) begin
            addr_hold_reg <= base_reg;
         end
      end
   end

endmodule

// File: tb/tb_pre_ram_loader.sv
// Directed and randomized tiles checked against a byte-list model of the loader.
module tb_pre_ram_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [7:0]  base_addr;
   logic [8:0]  num_bytes;
   logic        s_valid;
   logic [7:0]  s_data;
   logic        s_ready;
   logic        ram_we;
   logic [7:0]  ram_addr;
   logic [63:0] ram_data;
   logic        ram_read_req;
   logic        busy;
   logic        done;

   int n_vec = 0;
   int n_err = 0;

   logic [7:0]  tile_bytes [256];
   logic [7:0]  got_addr_q [$];
   logic [63:0] got_data_q [$];
   int          got_cyc_q  [$];
   logic [7:0]  exp_addr_q [$];
   logic [63:0] exp_data_q [$];
   int          rd_count;
   logic [7:0]  rd_addr;
   int          accepted;
   bit          fin;

   always #5 clk = ~clk;

   pre_ram_loader #(
      .ADDR_W     (8),
      .WORD_BYTES (8),
      .MAX_BYTES  (256)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .start        (start),
      .base_addr    (base_addr),
      .num_bytes    (num_bytes),
      .s_valid      (s_valid),
      .s_data       (s_data),
      .s_ready      (s_ready),
      .ram_we       (ram_we),
      .ram_addr     (ram_addr),
      .ram_data     (ram_data),
      .ram_read_req (ram_read_req),
      .busy         (busy),
      .done         (done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: tile bytes split into 8-byte words, little-endian, zero padded.
   task automatic build_expected(input logic [7:0] base, input int n);
      logic [63:0] w;
      exp_addr_q.delete();
      exp_data_q.delete();
      for (int k = 0; k < (n + 7) / 8; k++) begin
         w = 64'd0;
         for (int i = 0; i < 8; i++)
            if (k * 8 + i < n) w = w | (64'(tile_bytes[k * 8 + i]) << (8 * i));
         exp_addr_q.push_back(8'((int'(base) + k) % 256));
         exp_data_q.push_back(w);
      end
   endtask

   // mode 0: s_valid held high, 1: every other cycle, 2: random gaps.
   task automatic run_tile(input logic [7:0] base, input int n, input int mode, input bit pulse_start);
      bit pulsed;
      bit v;
      got_addr_q.delete();
      got_data_q.delete();
      got_cyc_q.delete();
      rd_count = 0;
      accepted = 0;
      fin      = 0;
      pulsed   = 0;
      build_expected(base, n);
      @(negedge clk);
      start     = 1'b1;
      base_addr = base;
      num_bytes = 9'(n);
      s_valid   = 1'b0;
      @(negedge clk);
      start     = 1'b0;
      base_addr = 8'($urandom);
      num_bytes = 9'($urandom);
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (cyc > 0) @(negedge clk);
         if (ram_we) begin
            got_addr_q.push_back(ram_addr);
            got_data_q.push_back(ram_data);
            got_cyc_q.push_back(cyc);
         end
         if (ram_read_req) begin
            rd_count++;
            rd_addr = ram_addr;
         end
         chk("we_rd_exclusive", 64'(ram_we & ram_read_req), 64'd0);
         if (done) begin
            fin = 1;
            break;
         end
         chk("busy_in_tile", 64'(busy), 64'd1);
         start = 1'b0;
         if (pulse_start && !pulsed && accepted == 2 && s_ready) begin
            start     = 1'b1;
            base_addr = base + 8'd100;
            num_bytes = 9'd5;
            pulsed    = 1;
         end
         case (mode)
            0:       v = 1'b1;
            1:       v = (cyc % 2 == 0);
            default: v = ($urandom_range(0, 3) != 0);
         endcase
         s_valid = v && (accepted < n);
         s_data  = s_valid ? tile_bytes[accepted] : 8'($urandom);
         if (s_valid && s_ready) accepted++;
      end
      s_valid = 1'b0;
      start   = 1'b0;
      chk("done_seen", 64'(fin), 64'd1);
      chk("bytes_accepted", 64'(accepted), 64'(n));
      chk("write_count", 64'(got_addr_q.size()), 64'(exp_addr_q.size()));
      for (int k = 0; k < exp_addr_q.size() && k < got_addr_q.size(); k++) begin
         chk("write_addr", 64'(got_addr_q[k]), 64'(exp_addr_q[k]));
         chk("write_data", got_data_q[k], exp_data_q[k]);
      end
      if (mode == 0 && got_cyc_q.size() > 1)
         chk("word_period", 64'(got_cyc_q[1] - got_cyc_q[0]), 64'd9);
      chk("read_count", 64'(rd_count), 64'd1);
      chk("read_addr", 64'(rd_addr), 64'(base));
      @(negedge clk);
      chk("idle_busy", 64'(busy), 64'd0);
      chk("idle_done", 64'(done), 64'd0);
      chk("hold_addr", 64'(ram_addr), 64'(base));
      if (exp_data_q.size() > 0)
         chk("hold_data", ram_data, exp_data_q[exp_data_q.size() - 1]);
      $display("tile base=%0d n=%0d mode=%0d writes=%0d", base, n, mode, got_addr_q.size());
   endtask

   // Present a start that must be rejected and watch for any activity.
   task automatic bad_start(input logic [8:0] n);
      @(negedge clk);
      start     = 1'b1;
      base_addr = 8'd5;
      num_bytes = n;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 6; i++) begin
         chk("rejected_busy", 64'(busy), 64'd0);
         chk("rejected_we", 64'(ram_we | ram_read_req | done), 64'd0);
         @(negedge clk);
      end
      $display("rejected start num_bytes=%0d", n);
   endtask

   initial begin
      reset     = 1'b1;
      start     = 1'b0;
      base_addr = 8'd0;
      num_bytes = 9'd0;
      s_valid   = 1'b0;
      s_data    = 8'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_s_ready", 64'(s_ready), 64'd0);
      chk("rst_strobes", 64'({ram_we, ram_read_req, done}), 64'd0);
      chk("rst_addr", 64'(ram_addr), 64'd0);
      chk("rst_data", ram_data, 64'd0);
      reset = 1'b0;

      // Sixteen incrementing bytes: two full words.
      for (int i = 0; i < 16; i++) tile_bytes[i] = 8'(i);
      run_tile(8'd10, 16, 0, 0);
      chk("req35_word0", (got_data_q.size() > 0) ? got_data_q[0] : 64'hx, 64'h0706050403020100);
      chk("req35_word1", (got_data_q.size() > 1) ? got_data_q[1] : 64'hx, 64'h0F0E0D0C0B0A0908);

      // Three-byte partial word.
      tile_bytes[0] = 8'hA5;
      tile_bytes[1] = 8'h5A;
      tile_bytes[2] = 8'hC3;
      run_tile(8'd20, 3, 0, 0);
      chk("req36_word0", (got_data_q.size() > 0) ? got_data_q[0] : 64'hx, 64'h0000000000C35AA5);

      // Address wrap-around past 255.
      for (int i = 0; i < 32; i++) tile_bytes[i] = 8'($urandom);
      run_tile(8'd254, 32, 0, 0);
      chk("wrap_addr2", (got_addr_q.size() > 2) ? 64'(got_addr_q[2]) : 64'hx, 64'd0);

      // Gapped s_valid with a stray start during FILL.
      for (int i = 0; i < 8; i++) tile_bytes[i] = 8'($urandom);
      run_tile(8'd40, 8, 1, 1);

      // Reset after five bytes of a sixteen-byte tile.
      for (int i = 0; i < 16; i++) tile_bytes[i] = 8'($urandom);
      @(negedge clk);
      start     = 1'b1;
      base_addr = 8'd3;
      num_bytes = 9'd16;
      @(negedge clk);
      start    = 1'b0;
      accepted = 0;
      for (int cyc = 0; cyc < 40 && accepted < 5; cyc++) begin
         if (cyc > 0) @(negedge clk);
         s_valid = 1'b1;
         s_data  = tile_bytes[accepted];
         if (s_ready) accepted++;
      end
      @(negedge clk);
      s_valid = 1'b0;
      reset   = 1'b1;
      #1;
      chk("midrst_busy", 64'(busy), 64'd0);
      chk("midrst_s_ready", 64'(s_ready), 64'd0);
      chk("midrst_addr", 64'(ram_addr), 64'd0);
      chk("midrst_data", ram_data, 64'd0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("midrst_strobes", 64'({ram_we, ram_read_req, done}), 64'd0);
      end
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("post_rst_quiet", 64'({busy, ram_we, ram_read_req, done}), 64'd0);
      end
      $display("reset mid-tile after %0d bytes", accepted);
      for (int i = 0; i < 8; i++) tile_bytes[i] = 8'($urandom);
      run_tile(8'd0, 8, 0, 0);

      // Out-of-range lengths are ignored.
      bad_start(9'd0);
      bad_start(9'd300);

      // Full-size tile, then random tiles with random gaps.
      for (int i = 0; i < 256; i++) tile_bytes[i] = 8'($urandom);
      run_tile(8'($urandom), 256, 2, 0);
      for (int t = 0; t < 6; t++) begin
         int n;
         n = $urandom_range(1, 256);
         for (int i = 0; i < 256; i++) tile_bytes[i] = 8'($urandom);
         run_tile(8'($urandom), n, 2, ($urandom_range(0, 1) == 1));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
